dma_lite_tx: RTL and testbench
==============================

Name: dma_lite_tx

Overview:
Lightweight egress DMA, the transmit counterpart of the byte-ingress metadata DMA. It buffers 32-bit words from the accelerator/result path in a word FIFO and serializes them LSB-first into an 8-bit byte stream for the UART TX or a byte-wide host link. Each packet is a configured byte length, reported with a done pulse and a cumulative byte counter.

Parameters:
FIFO_DEPTH, 16, word FIFO depth (power of two)
FIFO_PTR_W, 4, log2(FIFO_DEPTH); pointers are FIFO_PTR_W+1 bits (wrap bit)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_data  input  32  word to transmit; byte0 = [7:0]
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept; equals !fifo_full (combinational)
out_data  output  8  byte to sink (registered)
out_valid  output  1  out_data valid (registered)
out_ready  input  1  sink accepts byte
cfg_pkt_len  input  16  packet length in bytes; sampled on accepted start
cfg_start  input  1  single-cycle start request
busy  output  1  high when state != IDLE
dma_done  output  1  one-cycle pulse at packet end
dma_error  output  1  sticky error flag
dma_bytes_sent  output  32  cumulative payload bytes accepted by sink

Behaviour:
- Reset (async): FIFO pointers 0, state IDLE, out_data 0, out_valid 0, busy 0, dma_done 0, dma_error 0, dma_bytes_sent 0, internal byte index/remaining count 0.
- FIFO: push on in_valid && in_ready. Empty when pointers are equal; full when low bits are equal and wrap bits differ. Push and pop in the same cycle are legal when the FIFO is not full. Push is independent of state, so words may be preloaded before start.
- States: IDLE, LOAD, SEND, DONE.
- IDLE: cfg_start latches bytes_left = cfg_pkt_len and byte_idx = 0. If cfg_pkt_len == 0, go to DONE; otherwise go to LOAD.
- LOAD: if the FIFO is non-empty, pop the word into a holding register and drive out_data = byte0, out_valid = 1, then go to SEND. If empty, wait in LOAD with out_valid = 0.
- Latency: start sampled at edge N with a non-empty FIFO gives out_valid = 1 after edge N+1.
- SEND: a byte transfers on out_valid && out_ready. On each transfer, bytes_left decrements and dma_bytes_sent increments.
  - Last byte (bytes_left == 1): out_valid <= 0, go to DONE.
  - Else if byte_idx == 3 and the FIFO is non-empty: pop the next word and present its byte0 on the same edge (no bubble). If the FIFO is empty: out_valid <= 0, go to LOAD.
  - Else: byte_idx++ and out_data <= the next byte of the held word.
- Stall: while out_valid && !out_ready, out_data, out_valid and all state are held. out_valid never drops without a transfer.
- Partial final word: when cfg_pkt_len % 4 != 0, the unused upper bytes of the last word are discarded. That word is popped, so no residue remains for the next packet.
- DONE: dma_done = 1 for exactly one cycle, then IDLE; busy = 0 in IDLE.
- cfg_start outside IDLE: ignored, dma_error <= 1, and the current transfer is unaffected. dma_error clears only on reset.
- dma_bytes_sent wraps modulo 2^32 and is cleared only by reset.
- Reset mid-packet: everything returns to reset values immediately, including FIFO contents (discarded).

Optional Feature:
Macro DMA_TX_CSUM_EN.
- Defined: a state CSUM is inserted between the last payload byte and DONE. It sends one trailer byte = sum of all payload bytes mod 256, with the same handshake/stall rules. dma_done pulses after the trailer is accepted. The trailer is not counted in dma_bytes_sent. cfg_pkt_len == 0 sends trailer 0x00.
- Undefined: no trailer, no CSUM state.

Test Plan:
1. Push 0x44332211, 0x88776655; start with len=8; out_ready=1 -> bytes 11,22,33,44,55,66,77,88 on consecutive cycles, no bubble at the word boundary; dma_done one pulse; dma_bytes_sent=8; FIFO empty.
2. Push 0xDDCCBBAA, 0x1234FFEE; len=6 -> AA,BB,CC,DD,EE,FF; 0x34 and 0x12 never appear; a following len=4 packet of 0x04030201 -> 01,02,03,04.
3. Same as test 1 with out_ready pseudo-random 50% -> out_data stable during every stall, exactly 8 bytes delivered in order.
4. len=0 start -> out_valid never asserts; dma_done high one cycle after the start edge; dma_bytes_sent unchanged.
5. 16 pushes with no start -> in_ready=0 after the 16th; 17th word not accepted; then start with len=64 -> 64 bytes out, in_ready returns to 1 after the first pop.
6. cfg_start pulsed mid-packet -> dma_error=1 and stays 1; the packet completes normally. With DMA_TX_CSUM_EN and test 1 data -> a ninth byte 0x64 precedes dma_done.

Source files
------------

// File: rtl/dma_lite_tx.sv
// Egress DMA: 32-bit word FIFO serialized LSB-first into a byte stream, with per-packet done pulse.
// Optional DMA_TX_CSUM_EN appends a mod-256 checksum trailer byte after the payload.
module dma_lite_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [15:0] cfg_pkt_len,
    input  logic        cfg_start,
    output logic        busy,
    output logic        dma_done,
    output logic        dma_error,
    output logic [31:0] dma_bytes_sent
);
    // state   | meaning
    // S_IDLE  | waiting for cfg_start
    // S_LOAD  | waiting for a word to pop into the holding register
    // S_SEND  | presenting payload bytes of the held word
    // S_CSUM  | presenting the checksum trailer (DMA_TX_CSUM_EN only)
    // S_DONE  | one-cycle completion, dma_done high
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
`ifdef DMA_TX_CSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] bytes_sent_q, bytes_sent_d;
`ifdef DMA_TX_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    logic        fifo_empty, fifo_full, push, pop, xfer;
    logic [31:0] head;
    logic [1:0]  idx_nx;
    logic [7:0]  next_byte;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_PTR_W-1:0] == rd_ptr_q[FIFO_PTR_W-1:0]) &&
                        (wr_ptr_q[FIFO_PTR_W] != rd_ptr_q[FIFO_PTR_W]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q[FIFO_PTR_W-1:0]];
    assign xfer       = out_valid_q && out_ready;
    assign idx_nx     = byte_idx_q + 2'd1;

    always_comb begin
        case (idx_nx)
            2'd0:    next_byte = word_q[7:0];
            2'd1:    next_byte = word_q[15:8];
            2'd2:    next_byte = word_q[23:16];
            default: next_byte = word_q[31:24];
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        bytes_left_d = bytes_left_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        error_d      = error_q;
        bytes_sent_d = bytes_sent_q;
        pop          = 1'b0;
`ifdef DMA_TX_CSUM_EN
        csum_d       = csum_q;
`endif
        if (cfg_start && state_q != S_IDLE) error_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    bytes_left_d = cfg_pkt_len;
                    byte_idx_d   = 2'd0;
`ifdef DMA_TX_CSUM_EN
                    csum_d       = 8'd0;
`endif
                    if (cfg_pkt_len == 16'd0) begin
`ifdef DMA_TX_CSUM_EN
                        out_data_d  = 8'd0;
                        out_valid_d = 1'b1;
                        state_d     = S_CSUM;
`else
                        state_d     = S_DONE;
`endif
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    word_d      = head;
                    out_data_d  = head[7:0];
                    out_valid_d = 1'b1;
                    byte_idx_d  = 2'd0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    bytes_left_d = bytes_left_q - 16'd1;
                    bytes_sent_d = bytes_sent_q + 32'd1;
`ifdef DMA_TX_CSUM_EN
                    csum_d       = csum_q + out_data_q;
`endif
                    if (bytes_left_q == 16'd1) begin
                        // Remaining bytes of a partial last word are dropped; the word is already popped.
`ifdef DMA_TX_CSUM_EN
                        out_data_d = csum_q + out_data_q;
                        state_d    = S_CSUM;
`else
                        out_valid_d = 1'b0;
                        state_d     = S_DONE;
`endif
                    end else if (byte_idx_q == 2'd3) begin
                        byte_idx_d = 2'd0;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            word_d     = head;
                            out_data_d = head[7:0];
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = S_LOAD;
                        end
                    end else begin
                        byte_idx_d = idx_nx;
                        out_data_d = next_byte;
                    end
                end
            end
`ifdef DMA_TX_CSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_PTR_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            bytes_left_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            bytes_sent_q <= '0;
`ifdef DMA_TX_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            bytes_left_q <= bytes_left_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
            bytes_sent_q <= bytes_sent_d;
`ifdef DMA_TX_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign dma_done       = done_q;
    assign dma_error      = error_q;
    assign dma_bytes_sent = bytes_sent_q;
endmodule

// File: tb/tb_dma_lite_tx.sv
// Directed bench for dma_lite_tx; expected byte streams are built from the pushed words.
// Builds with or without DMA_TX_CSUM_EN (trailer expected when defined).
module tb_dma_lite_tx;
`ifdef DMA_TX_CSUM_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cfg_pkt_len;
    logic        cfg_start;
    logic        busy;
    logic        dma_done;
    logic        dma_error;
    logic [31:0] dma_bytes_sent;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] sent_exp = 0;
    int          f, l, d;

    always #5 clk = ~clk;

    dma_lite_tx dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_pkt_len(cfg_pkt_len), .cfg_start(cfg_start),
        .busy(busy), .dma_done(dma_done), .dma_error(dma_error),
        .dma_bytes_sent(dma_bytes_sent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_word(input logic [31:0] w, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push(input logic [31:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic start(input logic [15:0] len);
        cfg_pkt_len = len;
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
    endtask

    // Runs one packet from the negedge after the start edge until dma_done is seen.
    task automatic run_pkt(input string tag, input int rnd, input int pulse_at,
                           output int first, output int last, output int done_c);
        int         k, c, n;
        logic [7:0] sum, pdata;
        logic       stall;
        n = exp_q.size();
        sum = 8'd0;
        foreach (exp_q[i]) sum += exp_q[i];
        if (TRL == 1) exp_q.push_back(sum);
        k = 0; c = 0; first = -1; last = -1; done_c = -1; stall = 1'b0; pdata = 8'd0;
        while (done_c < 0 && c < 3000) begin
            if (stall) begin
                check({tag, " stall valid"}, out_valid, 1'b1);
                check({tag, " stall data"}, out_data, pdata);
            end
            if (dma_done) begin
                done_c = c;
            end else begin
                out_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                cfg_start = (c == pulse_at);
                if (out_valid && out_ready) begin
                    if (k < exp_q.size()) check({tag, " byte"}, out_data, exp_q[k]);
                    else check({tag, " extra byte"}, k, exp_q.size());
                    if (first < 0) first = c;
                    last = c;
                    k++;
                end
                stall = out_valid && !out_ready;
                pdata = out_data;
                @(negedge clk);
                c++;
            end
        end
        cfg_start = 1'b0;
        out_ready = 1'b1;
        check({tag, " done seen"}, (done_c >= 0), 1'b1);
        check({tag, " byte count"}, k, exp_q.size());
        sent_exp += 32'(n);
        check({tag, " bytes_sent"}, dma_bytes_sent, sent_exp);
        @(negedge clk);
        check({tag, " done one pulse"}, dma_done, 1'b0);
        check({tag, " idle after"}, busy, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_pkt_len = '0; cfg_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data", out_data, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst done", dma_done, 1'b0);
        check("rst error", dma_error, 1'b0);
        check("rst bytes_sent", dma_bytes_sent, 32'd0);
        check("rst in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // two full words, back-to-back bytes
        push(32'h44332211); push(32'h88776655);
        exp_word(32'h44332211, 4); exp_word(32'h88776655, 4);
        start(16'd8);
        check("t1 latency gap", out_valid, 1'b0);
        check("t1 busy", busy, 1'b1);
        run_pkt("t1", 0, -1, f, l, d);
        check("t1 first cycle", f, 1);
        check("t1 no bubble", l - f, 7 + TRL);

        // partial last word discarded, next packet clean
        push(32'hDDCCBBAA); push(32'h1234FFEE);
        exp_word(32'hDDCCBBAA, 4); exp_word(32'h1234FFEE, 2);
        start(16'd6);
        run_pkt("t2a", 0, -1, f, l, d);
        push(32'h04030201);
        exp_word(32'h04030201, 4);
        start(16'd4);
        run_pkt("t2b", 0, -1, f, l, d);

        // random backpressure
        push(32'h44332211); push(32'h88776655);
        exp_word(32'h44332211, 4); exp_word(32'h88776655, 4);
        start(16'd8);
        run_pkt("t3", 1, -1, f, l, d);

        // zero-length packet
        start(16'd0);
        run_pkt("t4", 0, -1, f, l, d);
        check("t4 done latency", d, TRL);

        // fill FIFO, overflow attempt, then 64-byte packet
        for (int i = 0; i < 16; i++) push(32'h03020100 + 32'(i) * 32'h04040404);
        check("t5 full", in_ready, 1'b0);
        in_data = 32'hDEADBEEF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5 still full", in_ready, 1'b0);
        out_ready = 1'b0;
        start(16'd64);
        check("t5 full before pop", in_ready, 1'b0);
        @(negedge clk);
        check("t5 ready after pop", in_ready, 1'b1);
        check("t5 first valid", out_valid, 1'b1);
        check("t5 first data", out_data, 8'h00);
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
        run_pkt("t5", 0, -1, f, l, d);

        // start while busy sets sticky error, packet unaffected
        check("t6 error clear", dma_error, 1'b0);
        push(32'h44332211); push(32'h88776655);
        exp_word(32'h44332211, 4); exp_word(32'h88776655, 4);
        start(16'd8);
        cfg_pkt_len = 16'd2;
        run_pkt("t6", 0, 3, f, l, d);
        check("t6 error set", dma_error, 1'b1);
        repeat (3) @(negedge clk);
        check("t6 error sticky", dma_error, 1'b1);

        // reset mid-packet discards FIFO contents and counters
        push(32'h11111111); push(32'h22222222);
        out_ready = 1'b0;
        start(16'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7 rst out_valid", out_valid, 1'b0);
        check("t7 rst out_data", out_data, 8'h00);
        check("t7 rst busy", busy, 1'b0);
        check("t7 rst error", dma_error, 1'b0);
        check("t7 rst bytes_sent", dma_bytes_sent, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        sent_exp = 32'd0;
        @(negedge clk);
        push(32'hA1B2C3D4);
        exp_word(32'hA1B2C3D4, 4);
        start(16'd4);
        run_pkt("t7", 0, -1, f, l, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
